// File: rtl/tt_ran_keygen.sv
// Random key generator: von Neumann debias + Galois-LFSR whitening of a raw entropy
// stream, repetition-count health test, and KEY_W-bit key capture on a valid/ready handshake.
module tt_ran_keygen #(
    parameter int               KEY_W     = 8,
    parameter int               LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter int               REP_LIMIT = 8,
    parameter int               VN_EN     = 1,
    parameter int               WHITEN_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_bit,
    input  logic             raw_valid,
    input  logic             req,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy,
    output logic             health_fail
);

    localparam int                CNT_W    = $clog2(KEY_W + 1);
    localparam int                REP_W    = 8;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(KEY_W - 1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REP_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HOLD,
        S_FAULT
    } state_e;

    state_e             state_q,       state_d;
    logic [LFSR_W-1:0]  lfsr_q,        lfsr_d;
    logic               vn_have_q,     vn_have_d;
    logic               vn_first_q,    vn_first_d;
    logic               prev_q,        prev_d;
    logic [REP_W-1:0]   rep_q,         rep_d;
    logic [KEY_W-1:0]   shreg_q,       shreg_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [KEY_W-1:0]   key_q,         key_d;
    logic               key_valid_q,   key_valid_d;
    logic               busy_q,        busy_d;
    logic               health_fail_q, health_fail_d;

    logic               emit;
    logic               dbit;
    logic               ebit;
    logic               trip;
    logic [KEY_W-1:0]   shreg_next;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        vn_have_d     = vn_have_q;
        vn_first_d    = vn_first_q;
        prev_d        = prev_q;
        rep_d         = rep_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        key_d         = key_q;
        key_valid_d   = key_valid_q;
        emit          = 1'b0;
        dbit          = 1'b0;
        trip          = 1'b0;

        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

        // Health test and debiaser only see cycles carrying a valid raw bit.
        if (raw_valid && (state_q != S_FAULT)) begin
            prev_d = raw_bit;
            rep_d  = (raw_bit == prev_q) ? rep_q + 1'b1 : REP_W'(1);
            trip   = (rep_d == REP_MAX);
            if (VN_EN != 0) begin
                if (!vn_have_q) begin
                    vn_have_d  = 1'b1;
                    vn_first_d = raw_bit;
                end else begin
                    vn_have_d = 1'b0;
                    if (vn_first_q != raw_bit) begin
                        emit = 1'b1;
                        dbit = vn_first_q;
                    end
                end
            end else begin
                emit = 1'b1;
                dbit = raw_bit;
            end
        end

        ebit       = dbit ^ ((WHITEN_EN != 0) ? lfsr_q[0] : 1'b0);
        shreg_next = {shreg_q[KEY_W-2:0], ebit};

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_COLLECT;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                if (emit) begin
                    shreg_d = shreg_next;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        key_d       = shreg_next;
                        key_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (key_ready) begin
                    key_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: ;
        endcase

        // A health trip overrides any key completion in the same cycle.
        if (trip) begin
            state_d     = S_FAULT;
            key_d       = key_q;
            key_valid_d = 1'b0;
        end

        busy_d        = (state_d == S_COLLECT) || (state_d == S_HOLD);
        health_fail_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= LFSR_W'(1);
            vn_have_q     <= 1'b0;
            vn_first_q    <= 1'b0;
            prev_q        <= 1'b0;
            rep_q         <= '0;
            shreg_q       <= '0;
            cnt_q         <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            vn_have_q     <= vn_have_d;
            vn_first_q    <= vn_first_d;
            prev_q        <= prev_d;
            rep_q         <= rep_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            busy_q        <= busy_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign busy        = busy_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_tt_ran_keygen.sv
// Self-checking bench for tt_ran_keygen: four instances covering every VN_EN/WHITEN_EN
// combination, fixed vector table, hand-written corner sequences and a randomized model run.
module tb_tt_ran_keygen;

    localparam int          KEY_W     = 8;
    localparam int          REP_LIMIT = 8;
    localparam logic [15:0] TAPS      = 16'hB400;
    localparam int          N_DUT     = 4;
    localparam logic [1:0]  PH_IDLE = 2'd0, PH_COLLECT = 2'd1, PH_HOLD = 2'd2, PH_FAULT = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_bit = 1'b0, raw_valid = 1'b0, req = 1'b0, key_ready = 1'b0;

    logic [KEY_W-1:0] key_o  [N_DUT];
    logic             kv_o   [N_DUT];
    logic             busy_o [N_DUT];
    logic             hf_o   [N_DUT];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Index bit 0 selects VN_EN, bit 1 selects WHITEN_EN.
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        tt_ran_keygen #(
            .KEY_W(KEY_W), .LFSR_W(16), .LFSR_TAPS(TAPS), .REP_LIMIT(REP_LIMIT),
            .VN_EN(g % 2), .WHITEN_EN(g / 2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit), .raw_valid(raw_valid),
            .req(req), .key(key_o[g]), .key_valid(kv_o[g]), .key_ready(key_ready),
            .busy(busy_o[g]), .health_fail(hf_o[g])
        );
    end

    // Behavioural model: emitted bits are accumulated arithmetically into a key word.
    typedef struct packed {
        logic [15:0] lfsr;
        logic        have;
        logic        first;
        logic [8:0]  run;
        logic        prev;
        logic [1:0]  phase;
        logic [31:0] acc;
        logic [7:0]  n;
        logic [7:0]  key;
        logic        kv;
    } model_t;

    model_t m [N_DUT];

    function automatic model_t model_step(model_t s, int vn, int wh,
                                          logic rv, logic rb, logic rq, logic rdy);
        model_t t = s;
        logic   emit = 1'b0;
        logic   d = 1'b0;
        logic   e;
        t.lfsr = (s.lfsr >> 1) ^ (s.lfsr[0] ? TAPS : 16'h0000);
        if (s.phase == PH_FAULT) return t;
        if (rv) begin
            t.run  = (s.run != 0 && rb == s.prev) ? s.run + 9'd1 : 9'd1;
            t.prev = rb;
            if (vn == 0) begin
                emit = 1'b1;
                d    = rb;
            end else if (!s.have) begin
                t.have  = 1'b1;
                t.first = rb;
            end else begin
                t.have = 1'b0;
                if (s.first != rb) begin
                    emit = 1'b1;
                    d    = s.first;
                end
            end
            if (int'(t.run) >= REP_LIMIT) begin
                t.phase = PH_FAULT;
                t.kv    = 1'b0;
                return t;
            end
        end
        e = d ^ ((wh != 0) ? s.lfsr[0] : 1'b0);
        case (s.phase)
            PH_IDLE: if (rq) begin
                t.phase = PH_COLLECT;
                t.acc   = 0;
                t.n     = 0;
            end
            PH_COLLECT: if (emit) begin
                t.acc = s.acc * 2 + 32'(e);
                t.n   = s.n + 8'd1;
                if (int'(t.n) == KEY_W) begin
                    t.key   = t.acc[7:0];
                    t.kv    = 1'b1;
                    t.phase = PH_HOLD;
                end
            end
            PH_HOLD: if (rdy) begin
                t.kv    = 1'b0;
                t.phase = PH_IDLE;
            end
            default: ;
        endcase
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int i, input string tag);
        check($sformatf("%s_key%0d", tag, i),  32'(key_o[i]),  32'(m[i].key));
        check($sformatf("%s_kv%0d", tag, i),   32'(kv_o[i]),   32'(m[i].kv));
        check($sformatf("%s_busy%0d", tag, i), 32'(busy_o[i]), 32'(m[i].phase == PH_COLLECT || m[i].phase == PH_HOLD));
        check($sformatf("%s_hf%0d", tag, i),   32'(hf_o[i]),   32'(m[i].phase == PH_FAULT));
    endtask

    // One clock: advance the models on the pre-edge inputs, then settle 1 time unit after the edge.
    task automatic tick();
        model_t nm [N_DUT];
        for (int i = 0; i < N_DUT; i++)
            nm[i] = rst_n ? model_step(m[i], i % 2, i / 2, raw_valid, raw_bit, req, key_ready) : m[i];
        @(posedge clk);
        for (int i = 0; i < N_DUT; i++) m[i] = nm[i];
        #1;
    endtask

    task automatic do_reset();
        raw_valid = 1'b0; raw_bit = 1'b0; req = 1'b0; key_ready = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < N_DUT; i++) begin
            m[i] = '0;
            m[i].lfsr = 16'h0001;
        end
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic       rv, rb, rq, rdy;
        logic [7:0] key;
        logic       kv, busy;
    } vec_t;

    function automatic vec_t mk(logic rv, logic rb, logic rq, logic rdy,
                                logic [7:0] k, logic kv, logic bz);
        vec_t v;
        v.rv = rv; v.rb = rb; v.rq = rq; v.rdy = rdy; v.key = k; v.kv = kv; v.busy = bz;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [16];
        logic [7:0] pat;
        logic       found;
        int         fault_cycles;

        // Basic capture table for the plain instance (index 0): bits of 8'hB2, MSB first.
        pat    = 8'hB2;
        tbl[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            tbl[i+1] = mk(1'b1, pat[7-i], 1'b0, 1'b0, (i == 7) ? 8'hB2 : 8'h00, i == 7, 1'b1);
        for (int i = 9; i < 14; i++)
            tbl[i] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < N_DUT; i++) check_dut(i, "reset");

        // No key without req.
        for (int i = 0; i < 10; i++) begin
            raw_valid = 1'b1; raw_bit = i[0]; tick();
        end
        check("noreq_busy", busy_o[0], 1'b0);
        check("noreq_kv", kv_o[0], 1'b0);

        do_reset();
        for (int r = 0; r < 16; r++) begin
            raw_valid = tbl[r].rv; raw_bit = tbl[r].rb; req = tbl[r].rq; key_ready = tbl[r].rdy;
            tick();
            check($sformatf("tbl%0d_key", r),  key_o[0],  tbl[r].key);
            check($sformatf("tbl%0d_kv", r),   kv_o[0],   tbl[r].kv);
            check($sformatf("tbl%0d_busy", r), busy_o[0], tbl[r].busy);
        end

        // Debias: pairs 01,11,10,00 emit 0 then 1; six "10" pairs finish key 8'h7F.
        do_reset();
        req = 1'b1; tick(); req = 1'b0;
        pat = 8'b01111000;
        for (int i = 0; i < 8; i++) begin
            raw_valid = 1'b1; raw_bit = pat[7-i]; tick();
        end
        check("vn_partial_kv", kv_o[1], 1'b0);
        check("vn_partial_busy", busy_o[1], 1'b1);
        for (int p = 0; p < 6; p++) begin
            raw_bit = 1'b1; tick();
            raw_bit = 1'b0;
            if (p == 5) check("vn_early_kv", kv_o[1], 1'b0);
            tick();
        end
        check("vn_key", key_o[1], 8'h7F);
        check("vn_kv", kv_o[1], 1'b1);

        // Health: eight raw 1s; on instance 0 the 8th bit also completes a key, fault wins.
        do_reset();
        req = 1'b1; tick(); req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raw_valid = 1'b1; raw_bit = 1'b1; tick();
            if (i == 6) check("hf_before", hf_o[0], 1'b0);
        end
        check("hf_set", hf_o[0], 1'b1);
        check("hf_kv", kv_o[0], 1'b0);
        check("hf_key_unchanged", key_o[0], 8'h00);
        raw_valid = 1'b0; req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hf_req_ignored", busy_o[0], 1'b0);
            check("hf_sticky", hf_o[0], 1'b1);
        end
        rst_n = 1'b0; #1;
        check("hf_async_clear", hf_o[0], 1'b0);
        do_reset();

        // raw_valid gaps carrying junk bits must not change the captured key.
        req = 1'b1; tick(); req = 1'b0;
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) begin
                raw_valid = 1'b0; raw_bit = 1'($urandom); tick();
            end
            raw_valid = 1'b1; raw_bit = pat[7-i]; tick();
            if (i < 7) check("gap_kv_early", kv_o[0], 1'b0);
        end
        check("gap_key", key_o[0], 8'hB2);
        check("gap_kv", kv_o[0], 1'b1);
        raw_valid = 1'b0; key_ready = 1'b1; tick();
        check("gap_ack_kv", kv_o[0], 1'b0);
        check("gap_ack_busy", busy_o[0], 1'b0);

        // Reset after 5 of 8 bits, then a fresh key.
        do_reset();
        req = 1'b1; tick(); req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            raw_valid = 1'b1; raw_bit = 1'b1; tick();
        end
        rst_n = 1'b0; #1;
        check("mid_rst_busy", busy_o[0], 1'b0);
        check("mid_rst_kv", kv_o[0], 1'b0);
        check("mid_rst_key", key_o[0], 8'h00);
        do_reset();
        req = 1'b1; tick(); req = 1'b0;
        pat = 8'h35;
        for (int i = 0; i < 8; i++) begin
            raw_valid = 1'b1; raw_bit = pat[7-i]; tick();
        end
        check("fresh_key", key_o[0], 8'h35);
        check("fresh_kv", kv_o[0], 1'b1);

        // Whitening: alternating raw bits, 100 consecutive keys against the model.
        do_reset();
        req = 1'b1; key_ready = 1'b1; raw_valid = 1'b1; raw_bit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                tick();
                raw_bit = ~raw_bit;
                if (kv_o[2] || m[2].kv) found = 1'b1;
            end
            check("wh_seen", found, 1'b1);
            if (found) begin
                check($sformatf("wh_key%0d", k), key_o[2], m[2].key);
                check($sformatf("wh_kv%0d", k), kv_o[2], m[2].kv);
            end
        end

        // Randomized run: every instance against its model each cycle.
        do_reset();
        fault_cycles = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            raw_valid = ($urandom_range(0, 3) != 0);
            raw_bit   = 1'($urandom);
            req       = ($urandom_range(0, 2) != 0);
            key_ready = 1'($urandom);
            tick();
            for (int i = 0; i < N_DUT; i++) check_dut(i, "rnd");
            if (m[0].phase == PH_FAULT) fault_cycles++;
            if (fault_cycles > 5 || $urandom_range(0, 399) == 0) begin
                fault_cycles = 0;
                rst_n = 1'b0; #1;
                do_reset();
                for (int i = 0; i < N_DUT; i++) check_dut(i, "rnd_rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
